// File: rtl/rc4_key_search.sv
// RC4 key-space search: for each candidate key, schedule S, generate keystream and decrypt the ROM message.
// Each decrypted byte is checked as it is written; the first non-printable byte rejects the candidate key.
//
// state     | meaning
// IDLE      | waiting for start after reset
// INIT      | S[i] = i, one write per cycle
// KSA       | key schedule, 4 phases per i (read S[i], read S[j], write S[j], write S[i])
// PRGA      | keystream, 6 phases per byte (read, read, write, write, read f, write plaintext)
// NEXT      | advance to the next key or give up
// FOUND     | every byte of the message decrypted to a valid character
// NOT_FOUND | key range exhausted or aborted
module rc4_key_search #(
   parameter int unsigned KEY_BYTES = 3,
   parameter int unsigned MSG_LEN   = 32,
   parameter logic [8*KEY_BYTES-1:0] KEY_FIRST = '0,
   parameter logic [8*KEY_BYTES-1:0] KEY_LAST  = 24'h3FFFFF,
   parameter logic [8*KEY_BYTES-1:0] KEY_STEP  = {{(8*KEY_BYTES-1){1'b0}}, 1'b1}
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   abort,
   output logic                   busy,
   output logic                   found,
   output logic                   not_found,
   output logic [8*KEY_BYTES-1:0] display_key,
   output logic [7:0]             s_address,
   output logic [7:0]             s_data,
   input  logic [7:0]             s_q,
   output logic                   s_wren,
   output logic [7:0]             rom_address,
   input  logic [7:0]             rom_q,
   output logic [7:0]             decrypt_address,
   output logic [7:0]             decrypt_data,
   output logic                   decrypt_wren
);

   localparam int KW = 8*KEY_BYTES;
   localparam int IW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
   localparam logic [7:0] LAST_K = 8'(MSG_LEN-1);

   typedef enum logic [2:0] {
      IDLE, INIT, KSA, PRGA, NEXT, FOUND, NOT_FOUND
   } state_t;

   state_t          state, state_n;
   logic [2:0]      phase, phase_n;
   logic [7:0]      i, i_n, j, j_n, k, k_n;
   logic [7:0]      si, si_n, sj, sj_n;
   logic [KW-1:0]   key, key_n;
   logic [IW-1:0]   kb_idx, kb_n;
   logic [7:0]      key_byte;
   logic [7:0]      p;
   logic            p_ok;
   logic            range_done;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         phase  <= '0;
         i      <= '0;
         j      <= '0;
         k      <= '0;
         si     <= '0;
         sj     <= '0;
         key    <= KEY_FIRST;
         kb_idx <= '0;
      end else begin
         state  <= state_n;
         phase  <= phase_n;
         i      <= i_n;
         j      <= j_n;
         k      <= k_n;
         si     <= si_n;
         sj     <= sj_n;
         key    <= key_n;
         kb_idx <= kb_n;
      end
   end

   // keybyte[0] is the most significant byte of the key
   always_comb begin
      key_byte = key[KW-1 -: 8];
      for (int b = 0; b < KEY_BYTES; b++) begin
         if (kb_idx == IW'(b)) key_byte = key[KW-1-8*b -: 8];
      end
   end

   assign p    = s_q ^ rom_q;
   assign p_ok = (p == 8'd32) || ((p >= 8'd97) && (p <= 8'd122));
   // compared one bit wider so the increment can never wrap back into range
   assign range_done = ({1'b0, key} + {1'b0, KEY_STEP}) > {1'b0, KEY_LAST};

   always_comb begin
      state_n         = state;
      phase_n         = phase;
      i_n             = i;
      j_n             = j;
      k_n             = k;
      si_n            = si;
      sj_n            = sj;
      key_n           = key;
      kb_n            = kb_idx;
      s_address       = 8'd0;
      s_data          = 8'd0;
      s_wren          = 1'b0;
      decrypt_address = 8'd0;
      decrypt_data    = 8'd0;
      decrypt_wren    = 1'b0;

      unique case (state)
         IDLE, FOUND, NOT_FOUND: begin
            if (start) begin
               state_n = INIT;
               key_n   = KEY_FIRST;
               phase_n = '0;
               i_n     = 8'd0;
               j_n     = 8'd0;
               k_n     = 8'd0;
            end
         end

         INIT: begin
            s_address = i;
            s_data    = i;
            s_wren    = 1'b1;
            i_n       = i + 8'd1;
            if (i == 8'hFF) begin
               state_n = KSA;
               j_n     = 8'd0;
               phase_n = '0;
               kb_n    = '0;
            end
         end

         KSA: begin
            unique case (phase)
               3'd0: begin
                  s_address = i;
                  phase_n   = 3'd1;
               end
               3'd1: begin
                  si_n      = s_q;
                  j_n       = j + s_q + key_byte;
                  s_address = j + s_q + key_byte;
                  phase_n   = 3'd2;
               end
               3'd2: begin
                  sj_n      = s_q;
                  s_address = j;
                  s_data    = si;
                  s_wren    = 1'b1;
                  phase_n   = 3'd3;
               end
               3'd3: begin
                  s_address = i;
                  s_data    = sj;
                  s_wren    = 1'b1;
                  i_n       = i + 8'd1;
                  phase_n   = 3'd0;
                  kb_n      = (kb_idx == IW'(KEY_BYTES-1)) ? '0 : kb_idx + 1'b1;
                  if (i == 8'hFF) begin
                     state_n = PRGA;
                     j_n     = 8'd0;
                     k_n     = 8'd0;
                  end
               end
               default: phase_n = 3'd0;
            endcase
         end

         PRGA: begin
            unique case (phase)
               3'd0: begin
                  s_address = i + 8'd1;
                  i_n       = i + 8'd1;
                  phase_n   = 3'd1;
               end
               3'd1: begin
                  si_n      = s_q;
                  j_n       = j + s_q;
                  s_address = j + s_q;
                  phase_n   = 3'd2;
               end
               3'd2: begin
                  sj_n      = s_q;
                  s_address = j;
                  s_data    = si;
                  s_wren    = 1'b1;
                  phase_n   = 3'd3;
               end
               3'd3: begin
                  s_address = i;
                  s_data    = sj;
                  s_wren    = 1'b1;
                  phase_n   = 3'd4;
               end
               3'd4: begin
                  // sum is unchanged by the swap, so the pre-swap values serve
                  s_address = si + sj;
                  phase_n   = 3'd5;
               end
               3'd5: begin
                  decrypt_address = k;
                  decrypt_data    = p;
                  decrypt_wren    = 1'b1;
                  phase_n         = 3'd0;
                  if (!p_ok) state_n = NEXT;
                  else if (k == LAST_K) state_n = FOUND;
                  else k_n = k + 8'd1;
               end
               default: phase_n = 3'd0;
            endcase
         end

         NEXT: begin
            if (abort || range_done) begin
               state_n = NOT_FOUND;
            end else begin
               state_n = INIT;
               key_n   = key + KEY_STEP;
               phase_n = '0;
               i_n     = 8'd0;
               j_n     = 8'd0;
               k_n     = 8'd0;
            end
         end

         default: state_n = IDLE;
      endcase
   end

   assign rom_address = k;
   assign display_key = key;
   assign found       = (state == FOUND);
   assign not_found   = (state == NOT_FOUND);
   assign busy        = (state != IDLE) && (state != FOUND) && (state != NOT_FOUND);

endmodule

// File: tb/tb_rc4_key_search.sv
// Bench for rc4_key_search: five instances with different key ranges, each with its own S RAM,
// message ROM and plaintext RAM, checked against a software RC4 model.
module tb_rc4_key_search;

   localparam int ND = 5;
   localparam int ML = 18;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start [ND];
   logic        abort [ND];
   logic        busy [ND];
   logic        found [ND];
   logic        not_found [ND];
   logic [23:0] display_key [ND];
   logic [7:0]  s_address [ND];
   logic [7:0]  s_data [ND];
   logic [7:0]  s_q [ND];
   logic        s_wren [ND];
   logic [7:0]  rom_address [ND];
   logic [7:0]  rom_q [ND];
   logic [7:0]  decrypt_address [ND];
   logic [7:0]  decrypt_data [ND];
   logic        decrypt_wren [ND];

   logic [7:0]  s_mem [ND][256];
   logic [7:0]  rom_mem [ND][256];
   logic [7:0]  dec_mem [ND][256];
   int          tries [ND];
   int          seq_err [ND];
   int          wr_cnt [ND];
   int          s_wr_cnt [ND];
   logic [7:0]  last_wa [ND];

   int total = 0;
   int bad = 0;

   logic [7:0]  m_s [256];
   logic [7:0]  m_ks [256];
   logic [7:0]  pt [ML];

   always #5 clock = ~clock;

   function automatic logic [23:0] kf(int g);
      case (g)
         2:       kf = 24'd1;
         4:       kf = 24'h0A0B0C;
         default: kf = 24'd0;
      endcase
   endfunction

   function automatic logic [23:0] kl(int g);
      case (g)
         0:       kl = 24'h3FFFFF;
         1:       kl = 24'd5;
         2, 3:    kl = 24'd9;
         default: kl = 24'h0A0B0C;
      endcase
   endfunction

   function automatic logic [23:0] kst(int g);
      kst = (g == 2 || g == 3) ? 24'd2 : 24'd1;
   endfunction

   for (genvar g = 0; g < ND; g++) begin : g_dut
      rc4_key_search #(
         .KEY_BYTES(3), .MSG_LEN(ML),
         .KEY_FIRST(kf(g)), .KEY_LAST(kl(g)), .KEY_STEP(kst(g))
      ) u_dut (
         .clock(clock), .reset(reset), .start(start[g]), .abort(abort[g]),
         .busy(busy[g]), .found(found[g]), .not_found(not_found[g]),
         .display_key(display_key[g]),
         .s_address(s_address[g]), .s_data(s_data[g]), .s_q(s_q[g]), .s_wren(s_wren[g]),
         .rom_address(rom_address[g]), .rom_q(rom_q[g]),
         .decrypt_address(decrypt_address[g]), .decrypt_data(decrypt_data[g]),
         .decrypt_wren(decrypt_wren[g])
      );
   end

   // synchronous memories plus a monitor of which keys reach their first plaintext write
   always @(posedge clock) begin
      for (int g = 0; g < ND; g++) begin
         s_q[g]   <= s_mem[g][s_address[g]];
         rom_q[g] <= rom_mem[g][rom_address[g]];
         if (s_wren[g]) begin
            s_mem[g][s_address[g]] <= s_data[g];
            s_wr_cnt[g] <= s_wr_cnt[g] + 1;
         end
         if (decrypt_wren[g]) begin
            dec_mem[g][decrypt_address[g]] <= decrypt_data[g];
            wr_cnt[g]  <= wr_cnt[g] + 1;
            last_wa[g] <= decrypt_address[g];
         end
         if (start[g] && !busy[g]) begin
            tries[g] <= 0;
         end else if (decrypt_wren[g] && decrypt_address[g] == 8'd0) begin
            if (display_key[g] != kf(g) + 24'(tries[g]) * kst(g)) seq_err[g] <= seq_err[g] + 1;
            tries[g] <= tries[g] + 1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // software RC4: KSA for key, then nbytes of keystream; m_s holds S afterwards
   task automatic model(input logic [23:0] key, input int nbytes);
      logic [7:0] t, mi, mj, kb;
      for (int x = 0; x < 256; x++) m_s[x] = 8'(x);
      mj = 8'd0;
      for (int x = 0; x < 256; x++) begin
         kb = key[23-8*(x%3) -: 8];
         mj = mj + m_s[x] + kb;
         t = m_s[x]; m_s[x] = m_s[mj]; m_s[mj] = t;
      end
      mi = 8'd0;
      mj = 8'd0;
      for (int x = 0; x < nbytes; x++) begin
         mi = mi + 8'd1;
         mj = mj + m_s[mi];
         t = m_s[mi]; m_s[mi] = m_s[mj]; m_s[mj] = t;
         t = m_s[mi] + m_s[mj];
         m_ks[x] = m_s[t];
      end
   endtask

   task automatic run(input int g, input int abort_key, output bit timed_out);
      @(negedge clock) start[g] = 1'b1;
      @(negedge clock) start[g] = 1'b0;
      timed_out = 1'b1;
      for (int c = 0; c < 20000; c++) begin
         if (abort_key >= 0 && busy[g] && display_key[g] == 24'(abort_key)) abort[g] = 1'b1;
         if (found[g] || not_found[g]) begin
            timed_out = 1'b0;
            break;
         end
         @(negedge clock);
      end
      abort[g] = 1'b0;
   endtask

   typedef struct {
      int          g;
      int          abort_key;
      logic        exp_found;
      logic        exp_nf;
      logic [23:0] exp_key;
      int          exp_tries;
   } vec_t;

   vec_t vecs [6];

   initial begin
      logic [8*ML-1:0] pt_vec;
      logic [7:0]      e_pt [ML];
      bit              to;
      int              sq0, wc0, n_bad, sw_sum, dw_sum;
      bit              hit;

      for (int g = 0; g < ND; g++) begin
         start[g] = 1'b0;
         abort[g] = 1'b0;
         for (int a = 0; a < 256; a++) rom_mem[g][a] = 8'd0;
      end

      //            dut abort found nf  key            tries
      vecs[0] = '{0, -1, 1'b1, 1'b0, 24'd3,       4};
      vecs[1] = '{1, -1, 1'b0, 1'b1, 24'd5,       6};
      vecs[2] = '{2, -1, 1'b0, 1'b1, 24'd9,       5};
      vecs[3] = '{3, -1, 1'b1, 1'b0, 24'd4,       3};
      vecs[4] = '{0,  2, 1'b0, 1'b1, 24'd2,       3};
      vecs[5] = '{4, -1, 1'b0, 1'b1, 24'h0A0B0C,  1};

      pt_vec = "the secret message";
      for (int x = 0; x < ML; x++) pt[x] = pt_vec[8*(ML-1-x) +: 8];

      model(24'd3, ML);
      for (int x = 0; x < ML; x++) rom_mem[0][x] = pt[x] ^ m_ks[x];
      model(24'd4, ML);
      for (int x = 0; x < ML; x++) begin
         rom_mem[2][x] = pt[x] ^ m_ks[x];
         rom_mem[3][x] = pt[x] ^ m_ks[x];
      end
      // boundary characters 'a', ' ', 'z' accepted; '{' (just above 'z') rejects at k = 5
      for (int x = 0; x < ML; x++) e_pt[x] = 8'h61;
      e_pt[1] = 8'h62; e_pt[2] = 8'h63; e_pt[3] = 8'h20; e_pt[4] = 8'h7A; e_pt[5] = 8'h7B;
      model(24'h0A0B0C, ML);
      for (int x = 0; x < ML; x++) rom_mem[4][x] = e_pt[x] ^ m_ks[x];

      repeat (3) @(negedge clock);
      for (int g = 0; g < ND; g++) begin
         check($sformatf("reset_flags_%0d", g),
               {27'd0, busy[g], found[g], not_found[g], s_wren[g], decrypt_wren[g]}, 32'd0);
         check($sformatf("reset_key_%0d", g), display_key[g], kf(g));
      end
      check("reset_addr_0", {s_address[0], s_data[0], rom_address[0], decrypt_address[0]}, 32'd0);
      reset = 1'b0;

      sw_sum = 0; dw_sum = 0;
      for (int g = 0; g < ND; g++) begin sw_sum -= s_wr_cnt[g]; dw_sum -= wr_cnt[g]; end
      repeat (20) @(negedge clock);
      for (int g = 0; g < ND; g++) begin sw_sum += s_wr_cnt[g]; dw_sum += wr_cnt[g]; end
      check("no_writes_before_start", sw_sum + dw_sum, 32'd0);

      for (int v = 0; v < 6; v++) begin
         int g;
         g   = vecs[v].g;
         sq0 = seq_err[g];
         wc0 = wr_cnt[g];
         run(g, vecs[v].abort_key, to);
         check($sformatf("v%0d_timeout", v), 32'(to), 32'd0);
         check($sformatf("v%0d_found", v), found[g], vecs[v].exp_found);
         check($sformatf("v%0d_not_found", v), not_found[g], vecs[v].exp_nf);
         check($sformatf("v%0d_busy", v), busy[g], 1'b0);
         check($sformatf("v%0d_key", v), display_key[g], vecs[v].exp_key);
         check($sformatf("v%0d_tries", v), tries[g], vecs[v].exp_tries);
         check($sformatf("v%0d_key_sequence", v), seq_err[g] - sq0, 32'd0);
         if (vecs[v].exp_found) begin
            n_bad = 0;
            for (int x = 0; x < ML; x++) if (dec_mem[g][x] !== pt[x]) n_bad++;
            check($sformatf("v%0d_plaintext_bad_bytes", v), n_bad, 32'd0);
            check($sformatf("v%0d_last_write_addr", v), last_wa[g], 32'(ML-1));
         end
         if (g == 4) begin
            check("e_write_count", wr_cnt[g] - wc0, 32'd6);
            check("e_last_write_addr", last_wa[g], 32'd5);
            check("e_rejected_byte", dec_mem[g][5], 32'h7B);
            check("e_accepted_bytes", {dec_mem[g][0], dec_mem[g][3], dec_mem[g][4]}, 32'h61207A);
            model(24'h0A0B0C, 6);
            n_bad = 0;
            for (int a = 0; a < 256; a++) if (s_mem[g][a] !== m_s[a]) n_bad++;
            check("e_s_ram_bad_entries", n_bad, 32'd0);
         end
      end

      // reset while dut 0 is writing a plaintext byte, then restart from KEY_FIRST
      @(negedge clock) start[0] = 1'b1;
      @(negedge clock) start[0] = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 5000 && !hit; c++) begin
         @(negedge clock);
         if (decrypt_wren[0]) hit = 1'b1;
      end
      check("prga_reached", 32'(hit), 32'd1);
      #1 reset = 1'b1;
      #1;
      check("midprga_reset_flags",
            {27'd0, busy[0], found[0], not_found[0], s_wren[0], decrypt_wren[0]}, 32'd0);
      check("midprga_reset_key", display_key[0], 24'd0);
      @(negedge clock) reset = 1'b0;
      sw_sum = s_wr_cnt[0];
      repeat (10) @(negedge clock);
      check("idle_after_reset_writes", s_wr_cnt[0] - sw_sum, 32'd0);
      sq0 = seq_err[0];
      run(0, -1, to);
      check("restart_timeout", 32'(to), 32'd0);
      check("restart_found", found[0], 1'b1);
      check("restart_key", display_key[0], 24'd3);
      check("restart_tries", tries[0], 32'd4);
      check("restart_key_sequence", seq_err[0] - sq0, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rc4_key_search.md
RC4_KEY_SEARCH -- requirements
Module: rc4_key_search

Interface
REQ-001 Parameter KEY_BYTES, default 3: secret key length in bytes; key width KW = 8*KEY_BYTES.
REQ-002 Parameter MSG_LEN, default 32: message length in bytes, range 1..256.
REQ-003 Parameter KEY_FIRST, default 0: first key tried after start.
REQ-004 Parameter KEY_LAST, default 24'h3FFFFF: last key tried, inclusive.
REQ-005 Parameter KEY_STEP, default 1: key increment, allowing several cores to stride one key range.
REQ-006 clock  in  1  sole clock; all flops on its rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  one-cycle pulse; accepted only in IDLE.
REQ-009 abort  in  1  level; stops the search at the next key boundary.
REQ-010 busy  out  1  high in every state except IDLE, FOUND and NOT_FOUND.
REQ-011 found  out  1  sticky; a valid key was found.
REQ-012 not_found  out  1  sticky; range exhausted or aborted without a hit.
REQ-013 display_key  out  KW  key currently under test.
REQ-014 s_address, s_data  out  8 each; s_q  in  8; s_wren  out  1  working S RAM port.
REQ-015 rom_address  out  8; rom_q  in  8  encrypted message ROM.
REQ-016 decrypt_address, decrypt_data  out  8 each; decrypt_wren  out  1  plaintext RAM.

Function
REQ-017 All RAM/ROM reads SHALL be synchronous: q is valid on the cycle after the address is presented. At most one S access SHALL occur per cycle.
REQ-018 The FSM SHALL use states IDLE, INIT, KSA, PRGA, NEXT, FOUND and NOT_FOUND.
REQ-019 IDLE SHALL go to INIT on start, load key = KEY_FIRST, and clear found and not_found.
REQ-020 INIT SHALL write S[i] = i for i = 0..255, one write per cycle, then go to KSA with i = j = 0.
REQ-021 KSA SHALL run i = 0..255 as: j = (j + S[i] + keybyte[i mod KEY_BYTES]) mod 256, then swap S[i] and S[j]. keybyte[0] is key[KW-1:KW-8] (MSB first). All sums are 8-bit and wrap.
REQ-022 On completion KSA SHALL go to PRGA with i = j = k = 0.
REQ-023 PRGA SHALL run for k = 0..MSG_LEN-1:
  - i = i + 1; j = j + S[i]; swap S[i] and S[j];
  - f = S[(S[i] + S[j]) mod 256];
  - p = f XOR rom_q[k];
  - write p to decrypt RAM address k with a one-cycle decrypt_wren.
REQ-024 A byte is valid iff p == 8'd32 or 8'd97 <= p <= 8'd122. Each byte SHALL be checked in the cycle it is written. On the first invalid byte, PRGA SHALL stop and go to NEXT (early reject); remaining bytes are not written.
REQ-025 If all MSG_LEN bytes are valid, the FSM SHALL go to FOUND and display_key SHALL hold the winning key.
REQ-026 NEXT SHALL go to NOT_FOUND if abort = 1, or if key > KEY_LAST - KEY_STEP, evaluated with KW+1-bit arithmetic so the increment never wraps. Otherwise it SHALL set key = key + KEY_STEP and go to INIT.
REQ-027 FOUND SHALL assert found, and NOT_FOUND SHALL assert not_found. Both states hold until reset or start; start re-enters INIT as in REQ-019.
REQ-028 abort SHALL be sampled only in NEXT. A key in progress completes, and a hit on it still yields FOUND.
REQ-029 start SHALL be ignored while busy = 1.
REQ-030 s_wren and decrypt_wren SHALL be 0 in IDLE, NEXT, FOUND and NOT_FOUND.
REQ-031 If KEY_FIRST > KEY_LAST, the first pass over KEY_FIRST SHALL still run, then the FSM SHALL go to NOT_FOUND.

Reset
REQ-032 Reset SHALL asynchronously force state to IDLE at any point, including mid-KSA or mid-PRGA.
REQ-033 Reset values: found = 0, not_found = 0, busy = 0, display_key = KEY_FIRST, all write enables 0, all addresses and data 0, i = j = k = 0.
REQ-034 After reset deasserts, the block SHALL wait for start; no RAM writes occur before start.

Verification
REQ-035 Plaintext "the secret message" encrypted with key 24'h000003 (MSG_LEN matching), defaults, start pulse -> found = 1 with display_key = 24'h000003, decrypt RAM equals plaintext, not_found = 0.
REQ-036 KEY_FIRST = 0, KEY_LAST = 5, ROM holding no solvable message -> keys 0..5 tried, then not_found = 1, found = 0, busy = 0, display_key = 5.
REQ-037 KEY_STEP = 2, KEY_FIRST = 1, message encrypted with key 4 -> only odd keys tried and not_found = 1; with KEY_FIRST = 0 -> found at key 4.
REQ-038 abort raised during key 2 of a 0..100 search -> key 2 completes, NEXT goes to NOT_FOUND, display_key = 2.
REQ-039 reset asserted mid-PRGA -> same cycle shows busy = 0 and wrens = 0; a later start restarts from KEY_FIRST.
REQ-040 Reference-model check: S RAM contents after KSA for key 24'h0A0B0C match a software RC4 KSA; the first rejected byte stops decrypt writes at the correct k.
